// File: rtl/fml_arbiter_pkg.sv
// Shared definitions for the FML arbiter slice.
//   FML_ADR_W / FML_DAT_W / FML_MSK_W : FML address, data and byte-mask widths
//   arb_state_t                       : arbiter FSM states (IDLE -> BUSY -> GAP -> IDLE)
package fml_arbiter_pkg;

    localparam int unsigned FML_ADR_W = 26;
    localparam int unsigned FML_DAT_W = 32;
    localparam int unsigned FML_MSK_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fml_arb_rr.sv
// Combinational rotating-priority picker, reusable by any shared-resource arbiter.
// Scans last+1, last+2, ... (mod nports) and returns the first requester.
// Ports:
//   req  in   nports    request vector
//   last in   id_width  index granted most recently (highest-priority slot is last+1)
//   pick out  id_width  chosen requester (0 when any=0)
//   any  out  1         at least one request present
module fml_arb_rr
    import fml_arbiter_pkg::*;
#(
    parameter int unsigned nports   = 4,
    parameter int unsigned id_width = 2
) (
    input  logic [nports-1:0]   req,
    input  logic [id_width-1:0] last,
    output logic [id_width-1:0] pick,
    output logic                any
);

    logic [2*nports-1:0] dbl;
    logic [nports-1:0]   rot;
    logic                found;

    always_comb begin
        // Duplicating req makes rot[i] == req[(last+1+i) mod nports].
        dbl   = {req, req};
        rot   = nports'(dbl >> (32'(last) + 32'd1));
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < nports; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pick  = id_width'((32'(last) + 32'd1 + i) % nports);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/fml_arbiter.sv
// Round-robin arbiter sharing one FML slave port of ddr_ctrl between nports masters.
// Grants one master at a time, forwards its command/address/data, routes fml_done back.
// Optional feature macro: FML_ARB_TIMEOUT_EN (adds 'timeout' parameter, BUSY watchdog, sticky err).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   m_rd, m_wr            per-master read/write requests, held until own m_done
//   m_adr/m_wdata/m_msk   per-master address/data/mask, master i at [i*W +: W]
//   m_done                one-cycle completion pulse to the granted master
//   m_rdata               read data broadcast (fml_rdata)
//   fml_rd, fml_wr        registered command to ddr_ctrl
//   fml_done, fml_rdata   completion pulse / read data from ddr_ctrl
//   fml_adr/wdata/msk     granted master's address/data/mask
//   gnt_id, busy, err     current/last grant, transfer outstanding, sticky timeout flag
module fml_arbiter
    import fml_arbiter_pkg::*;
#(
    parameter int unsigned nports   = 4,
    parameter int unsigned id_width = 2
`ifdef FML_ARB_TIMEOUT_EN
    ,
    parameter int unsigned timeout  = 1024
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [nports-1:0]             m_rd,
    input  logic [nports-1:0]             m_wr,
    input  logic [nports*FML_ADR_W-1:0]   m_adr,
    input  logic [nports*FML_DAT_W-1:0]   m_wdata,
    input  logic [nports*FML_MSK_W-1:0]   m_msk,
    output logic [nports-1:0]             m_done,
    output logic [FML_DAT_W-1:0]          m_rdata,
    output logic                          fml_rd,
    output logic                          fml_wr,
    input  logic                          fml_done,
    output logic [FML_ADR_W-1:0]          fml_adr,
    output logic [FML_DAT_W-1:0]          fml_wdata,
    output logic [FML_MSK_W-1:0]          fml_msk,
    input  logic [FML_DAT_W-1:0]          fml_rdata,
    output logic [id_width-1:0]           gnt_id,
    output logic                          busy,
    output logic                          err
);

    arb_state_t          state;
    logic [id_width-1:0] last;
    logic [id_width-1:0] pick;
    logic [nports-1:0]   req;
    logic                any;
    logic                tmo_hit;

    assign req = m_rd | m_wr;

    fml_arb_rr #(
        .nports   (nports),
        .id_width (id_width)
    ) u_rr (
        .req  (req),
        .last (last),
        .pick (pick),
        .any  (any)
    );

`ifdef FML_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(timeout + 1);

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    // cnt is 0 in the first BUSY cycle, so the abort lands in BUSY cycle 'timeout'.
    assign tmo_hit = (state == ARB_BUSY) && (cnt == CNT_W'(timeout - 1));
    assign err     = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ARB_BUSY)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (tmo_hit && !fml_done)
                err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ARB_IDLE;
            gnt_id <= '0;
            last   <= id_width'(nports - 1);
            busy   <= 1'b0;
            fml_rd <= 1'b0;
            fml_wr <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        gnt_id <= pick;
                        last   <= pick;
                        busy   <= 1'b1;
                        // Write wins; a concurrent read re-arbitrates after the GAP.
                        fml_wr <= m_wr[pick];
                        fml_rd <= m_rd[pick] & ~m_wr[pick];
                        state  <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (fml_done || tmo_hit) begin
                        fml_rd <= 1'b0;
                        fml_wr <= 1'b0;
                        busy   <= 1'b0;
                        state  <= ARB_GAP;
                    end
                end
                ARB_GAP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fml_adr   = '0;
        fml_wdata = '0;
        fml_msk   = '0;
        m_done    = '0;
        for (int unsigned i = 0; i < nports; i++) begin
            if (gnt_id == id_width'(i)) begin
                fml_adr   = m_adr[i*FML_ADR_W +: FML_ADR_W];
                fml_wdata = m_wdata[i*FML_DAT_W +: FML_DAT_W];
                fml_msk   = m_msk[i*FML_MSK_W +: FML_MSK_W];
                m_done[i] = (state == ARB_BUSY) && (fml_done || tmo_hit);
            end
        end
    end

    assign m_rdata = fml_rdata;

endmodule
